// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, control-bundle bit positions and bubble values.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hz_state_e;

   // WB bundle
   localparam int REGWRITE  = 0;
   localparam int MEMTOREG  = 1;
   // MEM bundle
   localparam int MEMREAD   = 0;
   localparam int MEMWRITE  = 1;
   // EX bundle
   localparam int ALUSRC    = 3;
   localparam int ALUOP_MSB = 2;
   localparam int ALUOP_LSB = 1;
   localparam int REGDST    = 0;

   localparam logic [1:0] WB_BUBBLE  = 2'b00;
   localparam logic [1:0] MEM_BUBBLE = 2'b00;
   localparam logic [3:0] EX_BUBBLE  = 4'b0000;

   localparam int unsigned WAIT_W = 8;

   function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/luh_detect.sv
// Load-use hazard comparator: the load in EX writes a register the instruction in ID reads.
module luh_detect (
   input  logic       ex_MemRead_i,
   input  logic [4:0] ex_RtAddr_i,
   input  logic [4:0] RsAddr_i,
   input  logic [4:0] RtAddr_i,
   input  logic       uses_rs_i,
   input  logic       uses_rt_i,
   output logic       luh_o
);

   // $zero is never a real dependency, so a load targeting it cannot cause a stall.
   assign luh_o = ex_MemRead_i && (ex_RtAddr_i != 5'd0) &&
                  ((uses_rs_i && (RsAddr_i == ex_RtAddr_i)) ||
                   (uses_rt_i && (RtAddr_i == ex_RtAddr_i)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: bubbles, freezes and flushes around the ID/EX register.
// Optional build macro ID_HAZARD_STATS_EN adds the stall_cnt_o stall-cycle counter.
module id_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] WB_i,
   input  logic [1:0] MEM_i,
   input  logic [3:0] EX_i,
   input  logic [4:0] RsAddr_i,
   input  logic [4:0] RtAddr_i,
   input  logic       uses_rs_i,
   input  logic       uses_rt_i,
   input  logic       ex_MemRead_i,
   input  logic [4:0] ex_RtAddr_i,
   input  logic       branch_taken_i,
   input  logic       dmem_busy_i,
   output logic [1:0] WB_o,
   output logic [1:0] MEM_o,
   output logic [3:0] EX_o,
   output logic       PC_Write_o,
   output logic       IF_ID_Write_o,
   output logic       IF_ID_Flush_o,
   output logic       ID_EX_Hold_o,
   output logic       err_o
`ifdef ID_HAZARD_STATS_EN
   ,
   output logic [15:0] stall_cnt_o
`endif
);

   hz_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic              luh_raw, luh_eff;

   luh_detect u_luh_detect (
      .ex_MemRead_i (ex_MemRead_i),
      .ex_RtAddr_i  (ex_RtAddr_i),
      .RsAddr_i     (RsAddr_i),
      .RtAddr_i     (RtAddr_i),
      .uses_rs_i    (uses_rs_i),
      .uses_rt_i    (uses_rt_i),
      .luh_o        (luh_raw)
   );

   // The cycle after a bubble still sees the same load in EX; masking guarantees one bubble only.
   assign luh_eff = luh_raw && (state_q != LOAD_STALL);

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = RUN;
      wait_d  = '0;
      err_d   = err_q;
      if (dmem_busy_i) begin
         state_d = MEM_WAIT;
         wait_d  = (state_q == MEM_WAIT) ? sat_inc(wait_q) : WAIT_W'(1);
         if (32'(wait_d) >= MAX_WAIT) err_d = 1'b1;
      end else if (luh_eff) begin
         state_d = LOAD_STALL;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      WB_o          = WB_i;
      MEM_o         = MEM_i;
      EX_o          = EX_i;
      PC_Write_o    = 1'b1;
      IF_ID_Write_o = 1'b1;
      IF_ID_Flush_o = 1'b0;
      ID_EX_Hold_o  = 1'b0;
      if (rst_i) begin
         WB_o          = WB_BUBBLE;
         MEM_o         = MEM_BUBBLE;
         EX_o          = EX_BUBBLE;
         PC_Write_o    = 1'b0;
         IF_ID_Write_o = 1'b0;
      end else if (dmem_busy_i) begin
         // Whole pipeline frozen: bundles pass untouched because ID/EX will not capture them anyway.
         PC_Write_o    = 1'b0;
         IF_ID_Write_o = 1'b0;
         ID_EX_Hold_o  = 1'b1;
      end else if (luh_eff) begin
         WB_o          = WB_BUBBLE;
         MEM_o         = MEM_BUBBLE;
         EX_o          = EX_BUBBLE;
         PC_Write_o    = 1'b0;
         IF_ID_Write_o = 1'b0;
      end else if (branch_taken_i) begin
         IF_ID_Flush_o = 1'b1;
      end
   end

   assign err_o = err_q && !rst_i;

`ifdef ID_HAZARD_STATS_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else if (!PC_Write_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: default MAX_WAIT and MAX_WAIT=3 instances share stimulus.
module tb_id_hazard_ctrl;
   import pipe_pkg::*;

   typedef enum {K_PASS, K_BUB, K_HOLD, K_FLUSH, K_RST} kind_e;

   typedef struct packed {
      logic [1:0] wb;
      logic [1:0] mem;
      logic [3:0] ex;
      logic       pc;
      logic       ifid;
      logic       flush;
      logic       hold;
      logic       err;
      logic       err3;
   } exp_t;

   localparam logic [1:0] WB_V  = 2'b11;
   localparam logic [1:0] MEM_V = 2'b01;
   localparam logic [3:0] EX_V  = 4'b1011;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] wb_in, mem_in;
   logic [3:0] ex_in;
   logic [4:0] rs, rt, ex_rt;
   logic       use_rs, use_rt, ex_mr, br, busy;

   logic [1:0] wb_a, mem_a, wb_b, mem_b;
   logic [3:0] ex_a, ex_b;
   logic       pc_a, ifid_a, flush_a, hold_a, err_a;
   logic       pc_b, ifid_b, flush_b, hold_b, err_b;
`ifdef ID_HAZARD_STATS_EN
   logic [15:0] scnt_a, scnt_b;
   int          tally = 0;
   bit          tally_valid = 1'b0;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   int   e3;

   always #5 clk = ~clk;

   id_hazard_ctrl #(.MAX_WAIT(255)) dut (
      .clk_i(clk), .rst_i(rst), .WB_i(wb_in), .MEM_i(mem_in), .EX_i(ex_in),
      .RsAddr_i(rs), .RtAddr_i(rt), .uses_rs_i(use_rs), .uses_rt_i(use_rt),
      .ex_MemRead_i(ex_mr), .ex_RtAddr_i(ex_rt), .branch_taken_i(br), .dmem_busy_i(busy),
      .WB_o(wb_a), .MEM_o(mem_a), .EX_o(ex_a), .PC_Write_o(pc_a), .IF_ID_Write_o(ifid_a),
      .IF_ID_Flush_o(flush_a), .ID_EX_Hold_o(hold_a), .err_o(err_a)
`ifdef ID_HAZARD_STATS_EN
      , .stall_cnt_o(scnt_a)
`endif
   );

   id_hazard_ctrl #(.MAX_WAIT(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .WB_i(wb_in), .MEM_i(mem_in), .EX_i(ex_in),
      .RsAddr_i(rs), .RtAddr_i(rt), .uses_rs_i(use_rs), .uses_rt_i(use_rt),
      .ex_MemRead_i(ex_mr), .ex_RtAddr_i(ex_rt), .branch_taken_i(br), .dmem_busy_i(busy),
      .WB_o(wb_b), .MEM_o(mem_b), .EX_o(ex_b), .PC_Write_o(pc_b), .IF_ID_Write_o(ifid_b),
      .IF_ID_Flush_o(flush_b), .ID_EX_Hold_o(hold_b), .err_o(err_b)
`ifdef ID_HAZARD_STATS_EN
      , .stall_cnt_o(scnt_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t make_exp(input kind_e k, input logic e, input logic e3v);
      exp_t x;
      x = '{wb: WB_V, mem: MEM_V, ex: EX_V, pc: 1'b1, ifid: 1'b1, flush: 1'b0,
            hold: 1'b0, err: e, err3: e3v};
      case (k)
         K_BUB:   begin x.wb = '0; x.mem = '0; x.ex = '0; x.pc = 1'b0; x.ifid = 1'b0; end
         K_HOLD:  begin x.pc = 1'b0; x.ifid = 1'b0; x.hold = 1'b1; end
         K_FLUSH: x.flush = 1'b1;
         K_RST:   begin x.wb = '0; x.mem = '0; x.ex = '0; x.pc = 1'b0; x.ifid = 1'b0;
                        x.err = 1'b0; x.err3 = 1'b0; end
         default: ;
      endcase
      return x;
   endfunction

   // Drives nothing itself: inputs are set by the caller, the expectation is queued, then compared.
   task automatic step(input string tag, input kind_e k, input logic e);
      exp_t x;
      sb_q.push_back(make_exp(k, e, e3[0]));
      @(negedge clk);
      x = sb_q.pop_front();
      check({tag, ".wb"},    {30'd0, wb_a},   {30'd0, x.wb});
      check({tag, ".mem"},   {30'd0, mem_a},  {30'd0, x.mem});
      check({tag, ".ex"},    {28'd0, ex_a},   {28'd0, x.ex});
      check({tag, ".pc"},    {31'd0, pc_a},   {31'd0, x.pc});
      check({tag, ".ifid"},  {31'd0, ifid_a}, {31'd0, x.ifid});
      check({tag, ".flush"}, {31'd0, flush_a},{31'd0, x.flush});
      check({tag, ".hold"},  {31'd0, hold_a}, {31'd0, x.hold});
      check({tag, ".err"},   {31'd0, err_a},  {31'd0, x.err});
      check({tag, ".pc3"},   {31'd0, pc_b},   {31'd0, x.pc});
      check({tag, ".hold3"}, {31'd0, hold_b}, {31'd0, x.hold});
      check({tag, ".err3"},  {31'd0, err_b},  {31'd0, x.err3});
`ifdef ID_HAZARD_STATS_EN
      if (tally_valid && !rst) check({tag, ".stall_cnt"}, {16'd0, scnt_a}, tally);
      if (rst) begin
         tally = 0;
         tally_valid = 1'b1;
      end else if (!x.pc) begin
         tally++;
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; ex_mr = 1'b0; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
      use_rs = 1'b0; use_rt = 1'b0; br = 1'b0; busy = 1'b0;
   endtask

   task automatic set_load_use_rs();
      ex_mr = 1'b1; ex_rt = 5'd5; rs = 5'd5; use_rs = 1'b1;
   endtask

   initial begin
      wb_in = WB_V; mem_in = MEM_V; ex_in = EX_V;
      idle_inputs();
      e3 = 0;
      rst = 1'b1;
      @(posedge clk); #1;
      step("rst0", K_RST, 1'b0);
      step("rst1", K_RST, 1'b0);

      rst = 1'b0;
      step("pass0", K_PASS, 1'b0);

      set_load_use_rs();
      step("luh_bubble", K_BUB, 1'b0);
      step("luh_release", K_PASS, 1'b0);

      idle_inputs(); set_load_use_rs(); ex_rt = 5'd0; rs = 5'd0;
      step("luh_r0", K_PASS, 1'b0);
      idle_inputs(); set_load_use_rs(); use_rs = 1'b0;
      step("luh_nouse", K_PASS, 1'b0);
      idle_inputs(); ex_mr = 1'b1; ex_rt = 5'd9; rt = 5'd9; use_rt = 1'b1; rs = 5'd9;
      step("luh_rt", K_BUB, 1'b0);
      idle_inputs();
      step("luh_rt_rel", K_PASS, 1'b0);

      busy = 1'b1;
      step("busy1", K_HOLD, 1'b0);
      step("busy2", K_HOLD, 1'b0);
      step("busy3", K_HOLD, 1'b0);
      e3 = 1;
      step("busy4", K_HOLD, 1'b0);
      busy = 1'b0;
      step("busy_rel", K_PASS, 1'b0);

      set_load_use_rs(); br = 1'b1;
      step("br_luh", K_BUB, 1'b0);
      idle_inputs();
      step("br_after", K_PASS, 1'b0);
      br = 1'b1;
      step("br_alone", K_FLUSH, 1'b0);
      br = 1'b0;
      step("br_done", K_PASS, 1'b0);
      br = 1'b1; busy = 1'b1;
      step("br_busy", K_HOLD, 1'b0);
      idle_inputs(); set_load_use_rs();
      step("memwait_luh", K_BUB, 1'b0);
      idle_inputs();
      step("memwait_luh_rel", K_PASS, 1'b0);

      busy = 1'b1;
      step("mw_a", K_HOLD, 1'b0);
      step("mw_b", K_HOLD, 1'b0);
      rst = 1'b1;
      e3 = 0;
      step("rst_in_mw", K_RST, 1'b0);
      idle_inputs();
      step("post_rst", K_PASS, 1'b0);

      set_load_use_rs();
      step("ls_a", K_BUB, 1'b0);
      rst = 1'b1;
      step("rst_in_ls", K_RST, 1'b0);
      rst = 1'b0;
      step("ls_after_rst", K_BUB, 1'b0);
      idle_inputs();
      step("ls_clear", K_PASS, 1'b0);

      busy = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         if (i == 4) e3 = 1;
         step($sformatf("b5_%0d", i), K_HOLD, 1'b0);
      end
      busy = 1'b0;
      step("b5_rel", K_PASS, 1'b0);
      step("b5_held", K_PASS, 1'b0);
      rst = 1'b1;
      e3 = 0;
      step("final_rst", K_RST, 1'b0);
      rst = 1'b0;
      step("final_pass", K_PASS, 1'b0);

      check("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
